// File: rtl/pcis_packet_arbiter.sv
// pcis_packet_arbiter
// Round-robin burst arbiter that merges NUM_APPS beat streams into one
// registered packet stream toward the PCIS read path. Once an app wins, it
// owns the output until it sends in_last or hits MAX_BEATS beats.
//
// Handshake: a beat transfers on a rising edge where valid && ready are both
// high; valid is never made to depend on ready, and a presented beat (data,
// slot, last) holds stable until it is taken.
module pcis_packet_arbiter #(
   parameter int NUM_APPS  = 4,
   parameter int DATA_W    = 512,
   parameter int SLOT_W    = 8,
   parameter int MAX_BEATS = 256,
   localparam int AW = (NUM_APPS > 1) ? $clog2(NUM_APPS) : 1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_APPS-1:0]        cfg_app_en,
   input  logic [NUM_APPS-1:0]        in_valid,
   input  logic [NUM_APPS*DATA_W-1:0] in_data,
   input  logic [NUM_APPS*SLOT_W-1:0] in_slot,
   input  logic [NUM_APPS-1:0]        in_last,
   output logic [NUM_APPS-1:0]        in_ready,
   output logic                       out_valid,
   output logic                       out_last,
   output logic [DATA_W-1:0]          out_data,
   output logic [SLOT_W-1:0]          out_slot,
   output logic [AW-1:0]              out_app,
   input  logic                       out_ready,
   output logic [NUM_APPS-1:0]        err_overlong,
   output logic                       busy,
   output logic [0:0]                 fsm_state
);

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] BURST = 1'b1;

   // Counter must hold MAX_BEATS itself, hence the +1.
   localparam int CW = $clog2(MAX_BEATS + 1);
   localparam logic [CW-1:0] LAST_CNT = CW'(MAX_BEATS - 1);

   logic [0:0]    state;
   logic [AW-1:0] grant;
   logic [AW-1:0] last_grant;
   logic [CW-1:0] beat_cnt;
   logic [AW-1:0] cand;
   logic          cand_found;
   logic          accept;
   logic          at_max;
   logic          end_burst;

   assign accept    = in_valid[grant] && in_ready[grant];
   assign at_max    = (beat_cnt == LAST_CNT);
   assign end_burst = accept && (in_last[grant] || at_max);
   assign busy      = (state == BURST) || out_valid;
   assign fsm_state = state;

   // Round-robin search starting just after the previous winner.
   always_comb begin
      cand_found = 1'b0;
      cand       = '0;
      for (int k = 1; k <= NUM_APPS; k++) begin
         if (!cand_found && in_valid[(int'(last_grant) + k) % NUM_APPS] &&
             cfg_app_en[(int'(last_grant) + k) % NUM_APPS]) begin
            cand_found = 1'b1;
            cand       = AW'((int'(last_grant) + k) % NUM_APPS);
         end
      end
   end

   // Only the granted app may move, and only when the output register frees up.
   always_comb begin
      in_ready = '0;
      if (state == BURST) begin
         in_ready[grant] = !out_valid || out_ready;
      end
   end

   // Arbitration FSM, beat counter and sticky overlong flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         grant        <= '0;
         last_grant   <= AW'(NUM_APPS - 1);
         beat_cnt     <= '0;
         err_overlong <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (cand_found) begin
                  grant    <= cand;
                  beat_cnt <= '0;
                  state    <= BURST;
               end
            end
            BURST: begin
               if (accept) begin
                  beat_cnt <= beat_cnt + CW'(1);
               end
               if (end_burst) begin
                  state      <= IDLE;
                  last_grant <= grant;
               end
               if (accept && at_max && !in_last[grant]) begin
                  err_overlong[grant] <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Output register: load on accept, drop valid once drained, hold on stall.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         out_data  <= '0;
         out_slot  <= '0;
         out_app   <= '0;
      end else if (accept) begin
         out_valid <= 1'b1;
         out_last  <= in_last[grant] || at_max;
         out_data  <= in_data[int'(grant)*DATA_W +: DATA_W];
         out_slot  <= in_slot[int'(grant)*SLOT_W +: SLOT_W];
         out_app   <= grant;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: doc/pcis_packet_arbiter.md
PCIS_PACKET_ARBITER -- requirements
Module: pcis_packet_arbiter

Interface
REQ-001 SHALL have parameter NUM_APPS, default 4, meaning the number of requesting application ports (2..8).
REQ-002 SHALL have parameter DATA_W, default 512, meaning the packet data width.
REQ-003 SHALL have parameter SLOT_W, default 8, meaning the packet slot field width.
REQ-004 SHALL have parameter MAX_BEATS, default 256, meaning the maximum beats per burst (AXI awlen+1 limit).
REQ-005 SHALL have one clock and an asynchronous, active-low reset, named as below.
REQ-006 SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-007 SHALL have port rst_n, input, 1, the asynchronous active-low reset.
REQ-008 SHALL have port cfg_app_en, input, NUM_APPS, the per-app arbitration enable.
REQ-009 SHALL have port in_valid, input, NUM_APPS, the per-app beat valid.
REQ-010 SHALL have port in_data, input, NUM_APPS*DATA_W, the per-app data (app i at bits [i*DATA_W +: DATA_W]).
REQ-011 SHALL have port in_slot, input, NUM_APPS*SLOT_W, the per-app slot.
REQ-012 SHALL have port in_last, input, NUM_APPS, the per-app last beat of a burst.
REQ-013 SHALL have port in_ready, output, NUM_APPS, the per-app beat accepted.
REQ-014 SHALL have ports out_valid/out_last (output, 1), out_data (output, DATA_W), out_slot (output, SLOT_W) and out_app (output, clog2(NUM_APPS)), forming the shared packet stream toward the PCIS read path.
REQ-015 SHALL have port out_ready, input, 1, the downstream accept.
REQ-016 SHALL have port err_overlong, output, NUM_APPS, a sticky per-app flag for a burst that exceeded MAX_BEATS.
REQ-017 SHALL have port busy, output, 1, high when the state is BURST or out_valid is high.

Function
REQ-018 SHALL implement FSM states IDLE and BURST.
REQ-019 In IDLE, SHALL select the first app i with in_valid[i] and cfg_app_en[i], searching round-robin from last_grant+1 (mod NUM_APPS); it SHALL register grant=i and enter BURST on the next edge; with no candidate it SHALL remain in IDLE.
REQ-020 In IDLE, in_ready SHALL be all zero (one-cycle arbitration bubble per burst).
REQ-021 In BURST, in_ready[grant] SHALL equal (!out_valid || out_ready); all other in_ready bits SHALL be 0.
REQ-022 An accepted beat (in_valid[grant] && in_ready[grant]) SHALL load the output register on the same edge: out_valid=1, with out_data, out_slot and out_last taken from that app, and out_app=grant; latency input-to-output SHALL be exactly 1 cycle.
REQ-023 out_valid SHALL clear on an edge where out_valid && out_ready and no new beat is accepted; the output register SHALL hold stable while out_valid && !out_ready.
REQ-024 A beat counter SHALL clear on entering BURST and increment per accepted beat.
REQ-025 An accepted beat with in_last=1 SHALL return the FSM to IDLE and set last_grant=grant.
REQ-026 An accepted beat that is beat number MAX_BEATS without in_last SHALL force out_last=1, set err_overlong[grant], return to IDLE, and set last_grant=grant.
REQ-027 Deasserting cfg_app_en[grant] mid-burst SHALL NOT abort the burst; it SHALL take effect at the next IDLE arbitration.
REQ-028 Simultaneous out_ready drain and new beat acceptance SHALL sustain 1 beat/cycle with no bubble inside a burst.
REQ-029 err_overlong bits SHALL clear only on reset.

Reset
REQ-030 While rst_n=0, asynchronously: state=IDLE, last_grant=NUM_APPS-1 (so app 0 has first priority), grant=0, counter=0, out_valid=0, out_last=0, out_data=0, out_slot=0, out_app=0, in_ready=0, err_overlong=0, busy=0.
REQ-031 Reset asserted mid-burst SHALL discard the in-flight output beat; after release, arbitration SHALL restart from app 0.

Verification
REQ-032 Apps 0 and 2 valid with 3-beat bursts, out_ready=1 -> app 0 burst (beats on cycles 2..4), 1 idle cycle, app 2 burst; out_app=0 then 2; in_ready[2]=0 during app 0's burst.
REQ-033 All 4 apps continuously requesting 1-beat bursts -> grant order 0,1,2,3,0 with each beat separated by one IDLE cycle.
REQ-034 out_ready=0 for 5 cycles mid-burst -> out_data is stable, in_ready[grant]=0 and no beat is lost or duplicated after release.
REQ-035 cfg_app_en=4'b1110 with app 0 valid -> app 0 is never granted; clearing cfg_app_en[1] during app 1's burst -> the burst completes.
REQ-036 MAX_BEATS=4 with app 1 sending 6 beats and no last -> 4th output beat has out_last=1, err_overlong=4'b0010, and the FSM re-arbitrates.
REQ-037 rst_n pulsed low during beat 2 of app 3 -> all outputs are 0 immediately, and the next grant goes to the lowest enabled valid app.
